axi_cfg_regbank: RTL and testbench

AXI_CFG_REGBANK -- requirements
Module: axi_cfg_regbank

---
 rtl/axi_cfg_regbank.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_cfg_regbank.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cfg_regbank.sv
// ----------------------------------------------------------------------------
// axi_cfg_regbank
//
// AXI4-Lite slave that fronts a compute core. It provides a control word,
// a bank of read/write configuration registers, a bank of read-only status
// words, and a pass-through window onto a core-side memory.
//
// Address map (word index = byte address >> 2):
//   any address bit at or above MEM_BASE_BIT set  -> memory window
//   word 0                                        -> ctrl
//   words 1 .. NUM_CFG_REGS                       -> cfg[0 ..]
//   words 64 .. 64+NUM_STAT_REGS-1                -> stat[0 ..]
//   everything else                               -> unmapped (SLVERR)
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET     clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*              AXI4-Lite write address/data/response
//   S_AXI_AR*/R*                 AXI4-Lite read address/data
//   busy                         core busy flag, visible as ctrl bit 1
//   stat_in                      packed status words, word i at [32i+31:32i]
//   cfg_out                      packed config registers, same packing
//   start_pulse                  one-cycle core start (ctrl bit 0 write)
//   mem_addr                     memory word address (byte address >> 2)
//   mem_wen, mem_wdata, mem_wstrb  memory write strobe, data, byte enables
//   mem_ren, mem_rdata           memory read strobe and returned data
// ----------------------------------------------------------------------------
module axi_cfg_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 30,
    parameter int NUM_CFG_REGS       = 8,
    parameter int NUM_STAT_REGS      = 4,
    parameter int MEM_BASE_BIT       = 24
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    input  logic                                       busy,
    input  logic [C_S_AXI_DATA_WIDTH*NUM_STAT_REGS-1:0] stat_in,
    output logic [C_S_AXI_DATA_WIDTH*NUM_CFG_REGS-1:0]  cfg_out,
    output logic                                       start_pulse,
    output logic [C_S_AXI_ADDR_WIDTH-3:0]              mem_addr,
    output logic                                       mem_wen,
    output logic                                       mem_ren,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              mem_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]            mem_wstrb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              mem_rdata
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [DW-1:0] CTRL_START  = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP, RD_MEM, RD_RESP
    } state_t;

    typedef enum logic [2:0] {
        SEL_CTRL, SEL_CFG, SEL_STAT, SEL_MEM, SEL_NONE
    } sel_t;

    function automatic logic [31:0] word_idx(input logic [AW-1:2] a);
        return 32'(a[MEM_BASE_BIT-1:2]);
    endfunction

    function automatic sel_t decode(input logic [AW-1:2] a);
        logic [31:0] idx;
        idx = word_idx(a);
        if (|a[AW-1:MEM_BASE_BIT])                              return SEL_MEM;
        if (idx == 32'd0)                                       return SEL_CTRL;
        if (idx >= 32'd1 && idx <= 32'(NUM_CFG_REGS))           return SEL_CFG;
        if (idx >= 32'd64 && idx < 32'(64 + NUM_STAT_REGS))     return SEL_STAT;
        return SEL_NONE;
    endfunction

    function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] s);
        logic [DW-1:0] m;
        for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    state_t          state;
    logic [DW-1:0]   cfg_q [NUM_CFG_REGS];

    // Captured beat of a write whose AW and W halves arrive on different cycles
    logic [AW-1:0]   aw_addr_p0;
    logic [DW-1:0]   w_data_p0;
    logic [SW-1:0]   w_strb_p0;

    logic [AW-1:0]   wr_addr_c;
    logic [DW-1:0]   wr_data_c;
    logic [SW-1:0]   wr_strb_c;
    logic            wr_commit_c;
    sel_t            wr_sel_c;
    logic [31:0]     wr_idx_c;
    logic            ctrl_ro_hit_c;

    sel_t            rd_sel_c;
    logic [31:0]     rd_idx_c;
    logic [DW-1:0]   rd_data_c;
    logic [1:0]      rd_resp_c;

    logic            unused_addr_lsbs;

    assign S_AXI_AWREADY = (state == IDLE) || (state == WR_HAVE_W);
    assign S_AXI_WREADY  = (state == IDLE) || (state == WR_HAVE_AW);
    // Writes win: a read is only accepted when no write half is being offered.
    assign S_AXI_ARREADY = (state == IDLE) && !(S_AXI_AWVALID || S_AXI_WVALID);

    // The half that arrived earlier comes from its capture register, the
    // half arriving now comes straight from the bus.
    assign wr_addr_c   = (state == WR_HAVE_AW) ? aw_addr_p0 : S_AXI_AWADDR;
    assign wr_data_c   = (state == WR_HAVE_W)  ? w_data_p0  : S_AXI_WDATA;
    assign wr_strb_c   = (state == WR_HAVE_W)  ? w_strb_p0  : S_AXI_WSTRB;
    assign wr_commit_c = ((state == IDLE)       && S_AXI_AWVALID && S_AXI_WVALID) ||
                         ((state == WR_HAVE_AW) && S_AXI_WVALID) ||
                         ((state == WR_HAVE_W)  && S_AXI_AWVALID);
    assign wr_sel_c    = decode(wr_addr_c[AW-1:2]);
    assign wr_idx_c    = word_idx(wr_addr_c[AW-1:2]);

    // Only ctrl bit 0 is writable; writing a 1 into any other enabled ctrl
    // bit is a write to read-only state and is refused.
    assign ctrl_ro_hit_c = |(wr_data_c & strb_mask(wr_strb_c) & ~CTRL_START);

    assign unused_addr_lsbs = ^{wr_addr_c[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        rd_sel_c  = decode(S_AXI_ARADDR[AW-1:2]);
        rd_idx_c  = word_idx(S_AXI_ARADDR[AW-1:2]);
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (rd_sel_c)
            SEL_CTRL: rd_data_c = {{(DW-2){1'b0}}, busy, 1'b0};
            SEL_CFG: begin
                for (int i = 0; i < NUM_CFG_REGS; i++)
                    if (rd_idx_c == 32'(i + 1)) rd_data_c = cfg_q[i];
            end
            SEL_STAT: begin
                for (int i = 0; i < NUM_STAT_REGS; i++)
                    if (rd_idx_c == 32'(64 + i)) rd_data_c = stat_in[DW*i +: DW];
            end
            SEL_MEM:  rd_data_c = '0;
            default:  rd_resp_c = RESP_SLVERR;
        endcase
    end

    for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_out
        assign cfg_out[DW*g +: DW] = cfg_q[g];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        start_pulse <= 1'b0;
        mem_wen     <= 1'b0;
        mem_ren     <= 1'b0;
        if (S_AXI_ARESET) begin
            state        <= IDLE;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
            for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= '0;
        end else if (wr_commit_c) begin
            state        <= WR_RESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= RESP_OKAY;
            case (wr_sel_c)
                SEL_CTRL: begin
                    if (ctrl_ro_hit_c) S_AXI_BRESP <= RESP_SLVERR;
                    else               start_pulse <= wr_strb_c[0] & wr_data_c[0];
                end
                SEL_CFG: begin
                    for (int i = 0; i < NUM_CFG_REGS; i++)
                        if (wr_idx_c == 32'(i + 1))
                            for (int b = 0; b < SW; b++)
                                if (wr_strb_c[b]) cfg_q[i][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
                SEL_MEM: begin
                    mem_wen   <= 1'b1;
                    mem_addr  <= wr_addr_c[AW-1:2];
                    mem_wdata <= wr_data_c;
                    mem_wstrb <= wr_strb_c;
                end
                default: S_AXI_BRESP <= RESP_SLVERR;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (S_AXI_AWVALID) begin
                        aw_addr_p0 <= S_AXI_AWADDR;
                        state      <= WR_HAVE_AW;
                    end else if (S_AXI_WVALID) begin
                        w_data_p0 <= S_AXI_WDATA;
                        w_strb_p0 <= S_AXI_WSTRB;
                        state     <= WR_HAVE_W;
                    end else if (S_AXI_ARVALID) begin
                        if (rd_sel_c == SEL_MEM) begin
                            mem_ren  <= 1'b1;
                            mem_addr <= S_AXI_ARADDR[AW-1:2];
                            state    <= RD_MEM;
                        end else begin
                            S_AXI_RDATA  <= rd_data_c;
                            S_AXI_RRESP  <= rd_resp_c;
                            S_AXI_RVALID <= 1'b1;
                            state        <= RD_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                // Memory returns data for the strobe issued during this cycle
                RD_MEM: begin
                    S_AXI_RDATA  <= mem_rdata;
                    S_AXI_RRESP  <= RESP_OKAY;
                    S_AXI_RVALID <= 1'b1;
                    state        <= RD_RESP;
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cfg_regbank.sv
// ----------------------------------------------------------------------------
// Directed testbench for axi_cfg_regbank with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_axi_cfg_regbank;

    logic         S_AXI_ACLK    = 1'b0;
    logic         S_AXI_ARESET  = 1'b1;
    logic [29:0]  S_AXI_AWADDR  = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA   = '0;
    logic [3:0]   S_AXI_WSTRB   = '0;
    logic         S_AXI_WVALID  = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY  = 1'b0;
    logic [29:0]  S_AXI_ARADDR  = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY  = 1'b0;
    logic         busy          = 1'b0;
    logic [127:0] stat_in       = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    logic [255:0] cfg_out;
    logic         start_pulse;
    logic [27:0]  mem_addr;
    logic         mem_wen;
    logic         mem_ren;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_rdata     = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Output values seen one cycle after a write commit, and one cycle later
    logic         snap_ok;
    logic         snap_start, snap_wen;
    logic [27:0]  snap_maddr;
    logic [31:0]  snap_wdata;
    logic [3:0]   snap_wstrb;
    logic         after_start, after_wen;

    axi_cfg_regbank #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(30),
        .NUM_CFG_REGS(8),
        .NUM_STAT_REGS(4),
        .MEM_BASE_BIT(24)
    ) dut (
        .S_AXI_ACLK(S_AXI_ACLK),       .S_AXI_ARESET(S_AXI_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR),   .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA),     .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID),   .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP),     .S_AXI_BVALID(S_AXI_BVALID),   .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR),   .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA),     .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID),   .S_AXI_RREADY(S_AXI_RREADY),
        .busy(busy),                   .stat_in(stat_in),             .cfg_out(cfg_out),
        .start_pulse(start_pulse),     .mem_addr(mem_addr),
        .mem_wen(mem_wen),             .mem_ren(mem_ren),
        .mem_wdata(mem_wdata),         .mem_wstrb(mem_wstrb),         .mem_rdata(mem_rdata)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one write; AW is offered aw_dly cycles and W w_dly cycles after start.
    task automatic axi_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            #1;
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge S_AXI_ACLK); #1;
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        snap_start = start_pulse; snap_wen = mem_wen; snap_maddr = mem_addr;
        snap_wdata = mem_wdata;   snap_wstrb = mem_wstrb;
        snap_ok = aw_done && w_done && S_AXI_BVALID;
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            @(posedge S_AXI_ACLK); #1;
            cyc++;
        end
        n_cmp++;
        if (snap_ok !== 1'b1) begin
            n_err++;
            $display("FAIL write_handshake addr=%h: aw=%0d w=%0d bvalid_at_commit=%b, required all 1", a, aw_done, w_done, snap_ok);
        end
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        after_start = start_pulse; after_wen = mem_wen;
        S_AXI_BREADY = 1'b0;
    endtask

    // Drives one read; lat counts edges from AR accept until RVALID is seen.
    task automatic axi_read(input logic [29:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        bit acc, hs;
        int cyc;
        acc = 0; cyc = 0; lat = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        while (!acc && cyc < 20) begin
            #1;
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge S_AXI_ACLK); #1;
            acc = hs;
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        if (acc) begin
            lat = 1;
            while (!S_AXI_RVALID && lat < 20) begin
                @(posedge S_AXI_ACLK); #1;
                lat++;
            end
        end
        d = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        S_AXI_ARESET = 1'b1;
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        n_cmp++;
        if ({S_AXI_BVALID, S_AXI_RVALID, start_pulse, mem_wen, mem_ren} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b required 00000", {S_AXI_BVALID, S_AXI_RVALID, start_pulse, mem_wen, mem_ren});
        end
        n_cmp++;
        if ({S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_rdata_resp: got %h required 0", {S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP});
        end
        n_cmp++;
        if (cfg_out !== 256'h0) begin
            n_err++;
            $display("FAIL reset_cfg: got %h required 0", cfg_out);
        end
        S_AXI_ARESET = 1'b0;
        #1;
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            n_err++;
            $display("FAIL idle_readies: got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_write_same_cycle();
        logic [1:0] r; logic [31:0] d; int lat;
        axi_write(30'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
        n_cmp++;
        if (r !== 2'b00) begin n_err++; $display("FAIL cfg0_bresp: got %b required 00", r); end
        n_cmp++;
        if (cfg_out[31:0] !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL cfg0_out: got %h required deadbeef", cfg_out[31:0]);
        end
        axi_read(30'h004, d, r, lat);
        n_cmp++;
        if ({d, r} !== {32'hDEAD_BEEF, 2'b00}) begin
            n_err++; $display("FAIL cfg0_readback: got %h/%b required deadbeef/00", d, r);
        end
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL reg_read_latency: got %0d required 1", lat); end
    endtask

    task automatic test_byte_strobe();
        logic [1:0] r;
        // AW ahead of W exercises the address-first path
        axi_write(30'h008, 32'h1122_3344, 4'hF, 0, 2, r);
        n_cmp++;
        if ({r, cfg_out[63:32]} !== {2'b00, 32'h1122_3344}) begin
            n_err++; $display("FAIL cfg1_preload: got %b/%h required 00/11223344", r, cfg_out[63:32]);
        end
        // W ahead of AW by three cycles, only byte 1 enabled
        axi_write(30'h008, 32'h0000_AB00, 4'h2, 3, 0, r);
        n_cmp++;
        if ({r, cfg_out[63:32]} !== {2'b00, 32'h1122_AB44}) begin
            n_err++; $display("FAIL cfg1_byte1: got %b/%h required 00/1122ab44", r, cfg_out[63:32]);
        end
        n_cmp++;
        if (cfg_out[31:0] !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL cfg0_untouched: got %h required deadbeef", cfg_out[31:0]);
        end
    endtask

    task automatic test_ctrl_start();
        logic [1:0] r; logic [31:0] d; int lat;
        busy = 1'b1;
        axi_write(30'h000, 32'h0000_0001, 4'h1, 0, 0, r);
        n_cmp++;
        if ({r, snap_start, after_start} !== 4'b0010) begin
            n_err++; $display("FAIL ctrl_start: resp/pulse/next got %b/%b/%b required 00/1/0", r, snap_start, after_start);
        end
        axi_read(30'h000, d, r, lat);
        n_cmp++;
        if ({d, r} !== {32'h0000_0002, 2'b00}) begin
            n_err++; $display("FAIL ctrl_read_busy: got %h/%b required 00000002/00", d, r);
        end
        busy = 1'b0;
        axi_read(30'h000, d, r, lat);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_read_idle: got %h required 0", d); end
        // Bit 0 set but its byte not enabled: no start
        axi_write(30'h000, 32'h0000_0001, 4'h0, 0, 0, r);
        n_cmp++;
        if ({r, snap_start} !== 3'b000) begin
            n_err++; $display("FAIL ctrl_strobe_gate: resp/pulse got %b/%b required 00/0", r, snap_start);
        end
        // Writing 1 into the read-only busy bit is refused
        axi_write(30'h000, 32'h0000_0003, 4'h1, 0, 0, r);
        n_cmp++;
        if ({r, snap_start} !== 3'b100) begin
            n_err++; $display("FAIL ctrl_ro_write: resp/pulse got %b/%b required 10/0", r, snap_start);
        end
    endtask

    task automatic test_mem_read();
        mem_rdata = 32'h1234_5678;
        S_AXI_ARADDR = 30'h0100_0010; S_AXI_ARVALID = 1'b1;
        #1;
        n_cmp++;
        if (S_AXI_ARREADY !== 1'b1) begin n_err++; $display("FAIL mem_arready: got %b required 1", S_AXI_ARREADY); end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        n_cmp++;
        if ({mem_ren, mem_addr, S_AXI_RVALID} !== {1'b1, 28'h040_0004, 1'b0}) begin
            n_err++; $display("FAIL mem_ren_addr: ren/addr/rvalid got %b/%h/%b required 1/0400004/0", mem_ren, mem_addr, S_AXI_RVALID);
        end
        @(posedge S_AXI_ACLK); #1;
        n_cmp++;
        if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, mem_ren} !== {1'b1, 32'h1234_5678, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL mem_rdata: rvalid/rdata/rresp/ren got %b/%h/%b/%b required 1/12345678/00/0", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, mem_ren);
        end
        mem_rdata = 32'h0;
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        n_cmp++;
        if ({S_AXI_RVALID, S_AXI_RDATA} !== {1'b1, 32'h1234_5678}) begin
            n_err++; $display("FAIL mem_rvalid_hold: got %b/%h required 1/12345678", S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_RREADY = 1'b0;
        n_cmp++;
        if (S_AXI_RVALID !== 1'b0) begin n_err++; $display("FAIL mem_rvalid_drop: got %b required 0", S_AXI_RVALID); end
    endtask

    task automatic test_mem_write();
        logic [1:0] r;
        axi_write(30'h0100_0020, 32'hCAFE_F00D, 4'h5, 0, 0, r);
        n_cmp++;
        if ({r, snap_wen, snap_maddr, snap_wdata, snap_wstrb} !== {2'b00, 1'b1, 28'h040_0008, 32'hCAFE_F00D, 4'h5}) begin
            n_err++; $display("FAIL mem_write: resp/wen/addr/data/strb got %b/%b/%h/%h/%h required 00/1/0400008/cafef00d/5", r, snap_wen, snap_maddr, snap_wdata, snap_wstrb);
        end
        n_cmp++;
        if (after_wen !== 1'b0) begin n_err++; $display("FAIL mem_wen_pulse: got %b required 0", after_wen); end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [31:0] d; int lat;
        logic [255:0] cfg_before;
        axi_read(30'h3FC, d, r, lat);
        n_cmp++;
        if ({d, r, 8'(lat)} !== {32'h0, 2'b10, 8'd1}) begin
            n_err++; $display("FAIL unmapped_read: data/resp/lat got %h/%b/%0d required 0/10/1", d, r, lat);
        end
        axi_read(30'h100, d, r, lat);
        n_cmp++;
        if ({d, r} !== {32'h1111_0000, 2'b00}) begin
            n_err++; $display("FAIL stat0_read: got %h/%b required 11110000/00", d, r);
        end
        axi_read(30'h10C, d, r, lat);
        n_cmp++;
        if ({d, r} !== {32'h4444_0003, 2'b00}) begin
            n_err++; $display("FAIL stat3_read: got %h/%b required 44440003/00", d, r);
        end
        axi_read(30'h110, d, r, lat);
        n_cmp++;
        if ({d, r} !== {32'h0, 2'b10}) begin
            n_err++; $display("FAIL past_stat_read: got %h/%b required 0/10", d, r);
        end
        cfg_before = cfg_out;
        axi_write(30'h100, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
        n_cmp++;
        if ({r, cfg_out} !== {2'b10, cfg_before}) begin
            n_err++; $display("FAIL stat_write: resp got %b required 10 (cfg changed=%b)", r, cfg_out !== cfg_before);
        end
        axi_read(30'h100, d, r, lat);
        n_cmp++;
        if ({d, r} !== {32'h1111_0000, 2'b00}) begin
            n_err++; $display("FAIL stat0_after_write: got %h/%b required 11110000/00", d, r);
        end
        axi_write(30'h024, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
        n_cmp++;
        if ({r, cfg_out} !== {2'b10, cfg_before}) begin
            n_err++; $display("FAIL past_cfg_write: resp got %b required 10 (cfg changed=%b)", r, cfg_out !== cfg_before);
        end
    endtask

    task automatic test_back_to_back();
        S_AXI_AWADDR = 30'h020; S_AXI_WDATA = 32'hA5A5_5A5A; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 30'h020;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        #1;
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b110) begin
            n_err++; $display("FAIL write_priority: readies got %b required 110", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n_cmp++;
        if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID} !== 4'b1000) begin
            n_err++; $display("FAIL b2b_bresp: bvalid/bresp/rvalid got %b/%b/%b required 1/00/0", S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        n_cmp++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA} !== {1'b0, 1'b1, 32'hA5A5_5A5A}) begin
            n_err++; $display("FAIL b2b_read: bvalid/rvalid/rdata got %b/%b/%h required 0/1/a5a55a5a", S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        logic [1:0] r;
        S_AXI_AWADDR = 30'h00C; S_AXI_AWVALID = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b010) begin
            n_err++; $display("FAIL have_aw_readies: got %b required 010", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        S_AXI_ARESET = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARESET = 1'b0;
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        n_cmp++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 4'b0111 || cfg_out !== 256'h0) begin
            n_err++; $display("FAIL reset_abandon: bvalid/readies got %b/%b required 0/111, cfg=%h required 0", S_AXI_BVALID, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, cfg_out);
        end
        // A fresh W must not pair with the abandoned address
        axi_write(30'h010, 32'h55AA_55AA, 4'hF, 2, 0, r);
        n_cmp++;
        if ({r, cfg_out[127:96], cfg_out[95:64]} !== {2'b00, 32'h55AA_55AA, 32'h0}) begin
            n_err++; $display("FAIL post_reset_write: resp/cfg3/cfg2 got %b/%h/%h required 00/55aa55aa/0", r, cfg_out[127:96], cfg_out[95:64]);
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_byte_strobe();
        test_ctrl_start();
        test_mem_read();
        test_mem_write();
        test_errors();
        test_back_to_back();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
